// File: rtl/mad_result_checker.sv
// mad_result_checker: in-order scoreboard for the MAD stream.
// Every accepted input transaction queues its expected A*B+C result. Each
// OE strobe is compared against the oldest queued value. The block keeps
// pass/fail counts, the first mismatch, sticky protocol error flags and a
// DONE flag that marks the end of a run.
module mad_result_checker #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 8,
    parameter int EXPECT_COUNT = 9,
    parameter int TIMEOUT      = 64
) (
    input  logic             MCLK,
    input  logic             nRST,
    input  logic             IE,
    input  logic             IREADY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             OE,
    input  logic [WIDTH-1:0] O,
    output logic [15:0]      PASS_CNT,
    output logic [15:0]      FAIL_CNT,
    output logic [2:0]       ERR_FLAGS,
    output logic [WIDTH-1:0] FIRST_EXP,
    output logic [WIDTH-1:0] FIRST_GOT,
    output logic             DONE
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [15:0]      in_cnt, in_cnt_nx;
    logic [TW-1:0]    tmo_cnt;
    logic             first_seen;

    logic             active;
    logic             fifo_empty, fifo_full;
    logic [WIDTH-1:0] head, exp_val;
    logic             push_ok, pop_cmp, pop_do;
    logic             underflow, overflow, wr_en, mismatch;
    logic             tmo_run, tmo_fire;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Handshake decode, FIFO status and compare datapath.
    // In FINISH the compare still runs so late results are counted, but the
    // read pointer is frozen; pop_cmp (compare) and pop_do (advance) differ there.
    always_comb begin
        active     = (state != S_FINISH);
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head       = mem[rd_ptr[AW-1:0]];
        exp_val    = A * B + C;
        push_ok    = IE && IREADY && active;
        pop_cmp    = OE && !fifo_empty;
        pop_do     = pop_cmp && active;
        underflow  = OE && fifo_empty;
        overflow   = push_ok && fifo_full && !pop_do;
        wr_en      = push_ok && !overflow;
        mismatch   = pop_cmp && (O != head);
        in_cnt_nx  = (push_ok && in_cnt != 16'hFFFF) ? in_cnt + 16'd1 : in_cnt;
        tmo_run    = (state == S_RUN || state == S_DRAIN) && !fifo_empty && !OE;
        tmo_fire   = (tmo_cnt == TW'(TIMEOUT));
    end

    // State register.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: run progress, drain completion and timeout abort.
    always_comb begin
        state_nx = state;
        if (tmo_fire) begin
            state_nx = S_FINISH;
        end else begin
            case (state)
                S_IDLE: begin
                    if (push_ok) begin
                        state_nx = (in_cnt_nx >= 16'(EXPECT_COUNT)) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_cnt_nx >= 16'(EXPECT_COUNT)) begin
                        state_nx = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state_nx = S_FINISH;
                    end
                end
                default: state_nx = S_FINISH;
            endcase
        end
    end

    // Output decode: DONE is high only in FINISH.
    always_comb begin
        DONE = (state == S_FINISH);
    end

    // FIFO pointers, accepted-transaction count and idle timeout counter.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            in_cnt  <= '0;
            tmo_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            in_cnt <= in_cnt_nx;
            if (tmo_run) begin
                tmo_cnt <= tmo_fire ? tmo_cnt : tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Expected-result storage; contents need no reset.
    always_ff @(posedge MCLK) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= exp_val;
        end
    end

    // Scoreboard counters, first-mismatch capture and sticky error flags.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            PASS_CNT   <= '0;
            FAIL_CNT   <= '0;
            ERR_FLAGS  <= '0;
            FIRST_EXP  <= '0;
            FIRST_GOT  <= '0;
            first_seen <= 1'b0;
        end else begin
            if (underflow) begin
                FAIL_CNT     <= sat_inc(FAIL_CNT);
                ERR_FLAGS[1] <= 1'b1;
            end else if (pop_cmp) begin
                if (mismatch) begin
                    FAIL_CNT <= sat_inc(FAIL_CNT);
                    if (!first_seen) begin
                        first_seen <= 1'b1;
                        FIRST_EXP  <= head;
                        FIRST_GOT  <= O;
                    end
                end else begin
                    PASS_CNT <= sat_inc(PASS_CNT);
                end
            end
            if (overflow) begin
                ERR_FLAGS[0] <= 1'b1;
            end
            if (tmo_fire) begin
                ERR_FLAGS[2] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mad_result_checker.sv
// Testbench for mad_result_checker: fixed vector tables, hand-written
// corner sequences and randomized traffic, all checked every cycle against
// a queue-based reference model of the scoreboard rules.
module tb_mad_result_checker;

    localparam int WIDTH        = 64;
    localparam int DEPTH        = 8;
    localparam int EXPECT_COUNT = 9;
    localparam int TIMEOUT      = 64;

    logic             MCLK = 1'b0;
    logic             nRST = 1'b0;
    logic             IE = 1'b0, IREADY = 1'b0, OE = 1'b0;
    logic [WIDTH-1:0] A = '0, B = '0, C = '0, O = '0;
    logic [15:0]      PASS_CNT, FAIL_CNT;
    logic [2:0]       ERR_FLAGS;
    logic [WIDTH-1:0] FIRST_EXP, FIRST_GOT;
    logic             DONE;

    mad_result_checker #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .EXPECT_COUNT(EXPECT_COUNT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .MCLK(MCLK), .nRST(nRST), .IE(IE), .IREADY(IREADY),
        .A(A), .B(B), .C(C), .OE(OE), .O(O),
        .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .ERR_FLAGS(ERR_FLAGS),
        .FIRST_EXP(FIRST_EXP), .FIRST_GOT(FIRST_GOT), .DONE(DONE)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] exp;
    } vec_t;

    vec_t plan [9];
    vec_t wvec [6];

    int errors = 0;
    int checks = 0;

    // Reference model state: expected-value queue plus run bookkeeping.
    logic [63:0] mq [$];
    int          m_in, m_pass, m_fail, m_idle;
    logic [2:0]  m_err;
    logic [63:0] m_fe, m_fg;
    bit          m_first, m_started, m_all_in, m_done;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in = 0; m_pass = 0; m_fail = 0; m_idle = 0;
        m_err = '0; m_fe = '0; m_fg = '0;
        m_first = 0; m_started = 0; m_all_in = 0; m_done = 0;
    endtask

    // Apply the scoreboard rules to the inputs present at the coming edge.
    task automatic model_step();
        bit push, empty, full, popped, fire, was_done;
        logic [63:0] e;
        push     = IE && IREADY;
        empty    = (mq.size() == 0);
        full     = (mq.size() == DEPTH);
        fire     = (m_idle == TIMEOUT);
        was_done = m_done;
        popped   = 0;
        if (m_started && !m_done && !empty && !OE) m_idle++;
        else m_idle = 0;
        if (OE) begin
            if (empty) begin
                if (m_fail < 65535) m_fail++;
                m_err[1] = 1'b1;
            end else begin
                if (O != mq[0]) begin
                    if (m_fail < 65535) m_fail++;
                    if (!m_first) begin
                        m_first = 1; m_fe = mq[0]; m_fg = O;
                    end
                end else if (m_pass < 65535) begin
                    m_pass++;
                end
                if (!was_done) begin
                    void'(mq.pop_front());
                    popped = 1;
                end
            end
        end
        if (push && !was_done) begin
            m_in++;
            e = A * B + C;
            if (full && !popped) m_err[0] = 1'b1;
            else mq.push_back(e);
        end
        if (fire) begin
            m_done = 1; m_err[2] = 1'b1;
        end else begin
            if (m_all_in && !was_done && empty) m_done = 1;
            if (push && !was_done) begin
                m_started = 1;
                if (m_in >= EXPECT_COUNT) m_all_in = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("pass_cnt",  64'(PASS_CNT),  64'(m_pass));
        chk("fail_cnt",  64'(FAIL_CNT),  64'(m_fail));
        chk("err_flags", 64'(ERR_FLAGS), 64'(m_err));
        chk("first_exp", FIRST_EXP, m_fe);
        chk("first_got", FIRST_GOT, m_fg);
        chk("done",      64'(DONE),      64'(m_done));
    endtask

    task automatic cyc();
        model_step();
        @(posedge MCLK);
        #1;
        check_model();
    endtask

    task automatic set_in(input bit ie, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input bit oe, input logic [63:0] o);
        IE = ie; IREADY = 1'b1; A = a; B = b; C = c; OE = oe; O = o;
    endtask

    task automatic idle_in();
        set_in(0, '0, '0, '0, 0, '0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_pass",  64'(PASS_CNT), 64'd0);
        chk("rst_fail",  64'(FAIL_CNT), 64'd0);
        chk("rst_err",   64'(ERR_FLAGS), 64'd0);
        chk("rst_fexp",  FIRST_EXP, 64'd0);
        chk("rst_fgot",  FIRST_GOT, 64'd0);
        chk("rst_done",  64'(DONE), 64'd0);
        idle_in();
        model_reset();
        @(negedge MCLK);
        @(negedge MCLK);
        nRST = 1'b1;
    endtask

    // The nine-transaction plan stream with results returned 'delay' cycles late.
    task automatic plan_run(input int bad_idx, input int delay, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (k < 9) set_in(1, plan[k].a, plan[k].b, plan[k].c, 0, '0);
            else set_in(0, '0, '0, '0, 0, '0);
            if (k >= delay && k - delay < 9) begin
                OE = 1'b1;
                O  = (k - delay == bad_idx) ? 64'd100 : plan[k - delay].exp;
            end
            cyc();
            if (k == 8 + delay) chk("done_at_last_oe", 64'(DONE), 64'd0);
            if (k == 9 + delay) chk("done_after_last_oe", 64'(DONE), 64'd1);
        end
        idle_in();
    endtask

    initial begin
        int seen;
        int pie, poe;

        plan[0] = '{64'd3,  64'd4,  64'd5,  64'd17};
        plan[1] = '{64'd5,  64'd6,  64'd7,  64'd37};
        plan[2] = '{64'd7,  64'd8,  64'd9,  64'd65};
        plan[3] = '{64'd9,  64'd10, 64'd11, 64'd101};
        plan[4] = '{64'd11, 64'd12, 64'd13, 64'd145};
        plan[5] = '{64'd13, 64'd14, 64'd15, 64'd197};
        plan[6] = '{64'd15, 64'd16, 64'd17, 64'd257};
        plan[7] = '{64'd17, 64'd18, 64'd19, 64'd325};
        plan[8] = '{64'd19, 64'd20, 64'd21, 64'd401};

        wvec[0] = '{64'd0, 64'd0, 64'd0, 64'd0};
        wvec[1] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64'd1};
        wvec[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
        wvec[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 64'd0};
        wvec[4] = '{64'd123456789, 64'd987654321, 64'd5, 64'd121932631112635274};
        wvec[5] = '{64'h8000_0000_0000_0000, 64'd2, 64'd7, 64'd7};

        // Clean run.
        do_reset();
        plan_run(-1, 3, 13);
        chk("clean_pass", 64'(PASS_CNT), 64'd9);
        chk("clean_fail", 64'(FAIL_CNT), 64'd0);
        chk("clean_err",  64'(ERR_FLAGS), 64'd0);

        // Fourth result corrupted.
        do_reset();
        plan_run(3, 3, 13);
        chk("bad_pass", 64'(PASS_CNT), 64'd8);
        chk("bad_fail", 64'(FAIL_CNT), 64'd1);
        chk("bad_fexp", FIRST_EXP, 64'd101);
        chk("bad_fgot", FIRST_GOT, 64'd100);

        // Wrap-around vectors, one push then one result each.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1, wvec[i].a, wvec[i].b, wvec[i].c, 0, '0);
            cyc();
            set_in(0, '0, '0, '0, 1, wvec[i].exp);
            cyc();
            chk("vec_pass", 64'(PASS_CNT), 64'(i + 1));
            chk("vec_fail", 64'(FAIL_CNT), 64'd0);
        end
        idle_in();

        // Overflow: nine pushes into an eight-entry FIFO with no results.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            set_in(1, plan[k].a, plan[k].b, plan[k].c, 0, '0);
            cyc();
        end
        chk("ovf_flag", 64'(ERR_FLAGS), 64'b001);
        for (int k = 0; k < 8; k++) begin
            set_in(0, '0, '0, '0, 1, plan[k].exp);
            cyc();
        end
        idle_in();
        cyc();
        chk("ovf_pass", 64'(PASS_CNT), 64'd8);
        chk("ovf_done", 64'(DONE), 64'd1);

        // Push and pop together at full: no overflow.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_in(1, plan[k].a, plan[k].b, plan[k].c, 0, '0);
            cyc();
        end
        set_in(1, plan[8].a, plan[8].b, plan[8].c, 1, plan[0].exp);
        cyc();
        chk("full_pp_err", 64'(ERR_FLAGS), 64'd0);
        for (int k = 1; k < 9; k++) begin
            set_in(0, '0, '0, '0, 1, plan[k].exp);
            cyc();
        end
        idle_in();
        cyc();
        chk("full_pp_pass", 64'(PASS_CNT), 64'd9);
        chk("full_pp_done", 64'(DONE), 64'd1);

        // Push and result in the same cycle into an empty FIFO: no bypass.
        do_reset();
        set_in(1, plan[0].a, plan[0].b, plan[0].c, 1, plan[0].exp);
        cyc();
        chk("nobyp_fail", 64'(FAIL_CNT), 64'd1);
        chk("nobyp_err",  64'(ERR_FLAGS), 64'b010);
        set_in(0, '0, '0, '0, 1, plan[0].exp);
        cyc();
        chk("nobyp_pass", 64'(PASS_CNT), 64'd1);
        idle_in();

        // Result before any push, then a full run, then a result after DONE.
        do_reset();
        set_in(0, '0, '0, '0, 1, 64'd17);
        cyc();
        chk("uf_first_fail", 64'(FAIL_CNT), 64'd1);
        plan_run(-1, 3, 13);
        set_in(0, '0, '0, '0, 1, 64'd0);
        cyc();
        idle_in();
        chk("uf_fail", 64'(FAIL_CNT), 64'd2);
        chk("uf_err1", 64'(ERR_FLAGS[1]), 64'd1);
        chk("uf_pass", 64'(PASS_CNT), 64'd9);

        // Timeout: two pushes and no results.
        do_reset();
        set_in(1, wvec[1].a, wvec[1].b, wvec[1].c, 0, '0);
        cyc();
        set_in(1, plan[0].a, plan[0].b, plan[0].c, 0, '0);
        cyc();
        idle_in();
        seen = -1;
        for (int n = 1; n <= TIMEOUT + 6; n++) begin
            cyc();
            if (DONE && seen < 0) seen = n;
        end
        chk("tmo_latency", 64'(seen), 64'(TIMEOUT));
        chk("tmo_err", 64'(ERR_FLAGS), 64'b100);

        // Reset mid-run, then a fresh clean run.
        do_reset();
        plan_run(-1, 3, 5);
        do_reset();
        plan_run(-1, 3, 13);
        chk("rerun_pass", 64'(PASS_CNT), 64'd9);
        chk("rerun_fail", 64'(FAIL_CNT), 64'd0);

        // Randomized traffic against the model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            case (r)
                0: begin pie = 80; poe = 40; end
                1: begin pie = 50; poe = 60; end
                2: begin pie = 30; poe = 30; end
                default: begin pie = 90; poe = 10; end
            endcase
            for (int k = 0; k < 250; k++) begin
                IE     = ($urandom_range(0, 99) < pie);
                IREADY = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 0) begin
                    A = {$urandom, $urandom}; B = {$urandom, $urandom}; C = {$urandom, $urandom};
                end else begin
                    A = 64'($urandom_range(0, 255)); B = 64'($urandom_range(0, 255));
                    C = 64'($urandom_range(0, 255));
                end
                OE = ($urandom_range(0, 99) < poe);
                if (mq.size() > 0 && $urandom_range(0, 7) != 0) O = mq[0];
                else O = {$urandom, $urandom};
                cyc();
            end
            idle_in();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
